mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single testbench memory port between, for example, the cache refill engine (requester 0) and the write-back engine (requester 1). Per-port valid/ready handshakes are converted into the memory's always-accepting request interface. Each fixed-latency memory response is routed back to the requester that issued it. Grant and contention counters are included for the timing-instrumentation flow.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one fixed-latency memory port between two requesters (e.g. cache
// refill engine on port 0, write-back engine on port 1). Round-robin
// arbitration grants at most one valid/ready handshake per cycle. The granted
// request is registered onto the memory request bus. A tag pipeline that
// matches the memory latency remembers who issued each request, so that the
// memory response can be steered back to that requester.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   arb_en                enables new grants (in-flight responses still drain)
//   rqN_valid/we/addr/    requester N request (N = 0, 1)
//   rqN_wdata
//   rqN_ready             combinational grant to requester N
//   rqN_resp_valid/rdata  registered response to requester N (rdata 0 on
//                         write acks and whenever the strobe is low)
//   mem_req_*             registered memory request (valid is a 1-cycle pulse)
//   mem_resp_valid/rdata  memory response, MEM_LATENCY cycles after mem_req
//   idle                  nothing in the issue register or tag pipeline
//   resp_err              sticky: memory response and tag pipeline disagreed
//   grant_cnt0/1          grants per requester (wrapping)
//   conflict_cnt          cycles with both requesters valid while enabled
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arb_en,

    input  logic              rq0_valid,
    input  logic              rq0_we,
    input  logic [31:0]       rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ready,
    output logic              rq0_resp_valid,
    output logic [DATA_W-1:0] rq0_resp_rdata,

    input  logic              rq1_valid,
    input  logic              rq1_we,
    input  logic [31:0]       rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ready,
    output logic              rq1_resp_valid,
    output logic [DATA_W-1:0] rq1_resp_rdata,

    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [31:0]       mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,

    output logic              idle,
    output logic              resp_err,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int               LAST    = MEM_LATENCY;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic prio;
    logic grant0;
    logic grant1;
    logic grant_any;
    logic conflict;

    logic [LAST:0] tag_vld_p;
    logic [LAST:0] tag_id_p;
    logic [LAST:0] tag_we_p;

    logic resp_hit;
    logic route0;
    logic route1;

    // Read data is forwarded only for a routed read; everything else is zero.
    function automatic logic [DATA_W-1:0] route_rdata(input logic              sel,
                                                      input logic [DATA_W-1:0] data);
        return sel ? data : '0;
    endfunction

    // ---- stage p0: arbitration (combinational) ----
    // A port wins if it is the only one asking or if the pointer favours it.
    // rst_n gates ready so no handshake can appear to complete during reset.
    assign rq0_ready = rst_n & arb_en & rq0_valid & (~rq1_valid | ~prio);
    assign rq1_ready = rst_n & arb_en & rq1_valid & (~rq0_valid |  prio);
    assign grant0    = rq0_ready;
    assign grant1    = rq1_ready;
    assign grant_any = grant0 | grant1;
    assign conflict  = rq0_valid & rq1_valid & arb_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            mem_req_valid <= grant_any;
            if (grant_any) begin
                // Next turn goes to the port that was not just served.
                prio          <= grant0;
                mem_req_we    <= grant1 ? rq1_we    : rq0_we;
                mem_req_addr  <= grant1 ? rq1_addr  : rq0_addr;
                mem_req_wdata <= grant1 ? rq1_wdata : rq0_wdata;
            end
        end
    end

    // ---- stage p1..p(LAST+1): tag pipeline tracking outstanding requests ----
    // Entry 0 is loaded together with the issue register; entry LAST lines up
    // with the cycle in which the memory response is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
            tag_id_p  <= '0;
            tag_we_p  <= '0;
        end else begin
            tag_vld_p[0] <= grant_any;
            tag_id_p[0]  <= grant1;
            tag_we_p[0]  <= grant1 ? rq1_we : rq0_we;
            for (int i = 1; i <= LAST; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
                tag_we_p[i]  <= tag_we_p[i-1];
            end
        end
    end

    // ---- stage p(LAST+2): response routing ----
    assign resp_hit = mem_resp_valid & tag_vld_p[LAST];
    assign route0   = resp_hit & ~tag_id_p[LAST];
    assign route1   = resp_hit &  tag_id_p[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq0_resp_valid <= 1'b0;
            rq1_resp_valid <= 1'b0;
            rq0_resp_rdata <= '0;
            rq1_resp_rdata <= '0;
            resp_err       <= 1'b0;
        end else begin
            rq0_resp_valid <= route0;
            rq1_resp_valid <= route1;
            rq0_resp_rdata <= route_rdata(route0 & ~tag_we_p[LAST], mem_resp_rdata);
            rq1_resp_rdata <= route_rdata(route1 & ~tag_we_p[LAST], mem_resp_rdata);
            // A response without a tag, or a tag whose response never came.
            if (mem_resp_valid != tag_vld_p[LAST]) begin
                resp_err <= 1'b1;
            end
        end
    end

    // Statistics counters, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant0) begin
                grant_cnt0 <= grant_cnt0 + CNT_ONE;
            end
            if (grant1) begin
                grant_cnt1 <= grant_cnt1 + CNT_ONE;
            end
            if (conflict) begin
                conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end

    assign idle = ~mem_req_valid & ~(|tag_vld_p);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic        rq0_valid, rq0_we, rq1_valid, rq1_we;
    logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
    logic        rq0_ready, rq1_ready;
    logic        rq0_resp_valid, rq1_resp_valid;
    logic [31:0] rq0_resp_rdata, rq1_resp_rdata;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        idle, resp_err;
    logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(L), .CNT_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ready(rq0_ready), .rq0_resp_valid(rq0_resp_valid), .rq0_resp_rdata(rq0_resp_rdata),
        .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ready(rq1_ready), .rq1_resp_valid(rq1_resp_valid), .rq1_resp_rdata(rq1_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .idle(idle), .resp_err(resp_err),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
    );

    // Cycle counter: the value seen at a negedge names the current cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory model sharing the arbiter reset.
    logic [31:0]  mem [256];
    logic [L-1:0] mv;
    logic [31:0]  md [L];
    logic         inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
            for (int i = 0; i < L; i++) md[i] <= 32'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            mv[0] <= mem_req_valid;
            md[0] <= mem_req_we ? 32'h0 : mem[mem_req_addr[9:2]];
            if (mem_req_valid && mem_req_we) mem[mem_req_addr[9:2]] <= mem_req_wdata;
            for (int i = 1; i < L; i++) begin
                mv[i] <= mv[i-1];
                md[i] <= md[i-1];
            end
        end
    end

    assign mem_resp_valid = mv[L-1] | inj;
    assign mem_resp_rdata = inj ? 32'hBAD0BAD0 : md[L-1];

    // Response log per port: cycle and data of every strobe.
    int          q0c[$], q1c[$];
    logic [31:0] q0d[$], q1d[$];
    int          bad_rd = 0;

    always @(negedge clk) begin
        if (rq0_resp_valid) begin q0c.push_back(cyc); q0d.push_back(rq0_resp_rdata); end
        if (rq1_resp_valid) begin q1c.push_back(cyc); q1d.push_back(rq1_resp_rdata); end
        if (!rq0_resp_valid && rq0_resp_rdata != 32'h0) bad_rd++;
        if (!rq1_resp_valid && rq1_resp_rdata != 32'h0) bad_rd++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q0c.delete(); q1c.delete(); q0d.delete(); q1d.delete();
    endtask

    task automatic do_reset();
        rq0_valid = 1'b0; rq1_valid = 1'b0; arb_en = 1'b1; inj = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
    endtask

    // Present a request and hold it until granted; returns the handshake cycle.
    // Called and returns one time unit after a rising edge.
    task automatic req(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int gcyc);
        bit done = 1'b0;
        gcyc = -1;
        if (port == 0) begin
            rq0_valid = 1'b1; rq0_we = we; rq0_addr = addr; rq0_wdata = wdata;
        end else begin
            rq1_valid = 1'b1; rq1_we = we; rq1_addr = addr; rq1_wdata = wdata;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if ((port == 0) ? rq0_ready : rq1_ready) begin
                gcyc = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (port == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
        if (!done) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (idle) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int gw, gr, s, g0a, g1a, g0b, g1b, gq;

    initial begin
        rst_n = 1'b1; arb_en = 1'b1; inj = 1'b0;
        rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = 32'h0; rq0_wdata = 32'h0;
        rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = 32'h0; rq1_wdata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'd0);
        check("rst_idle", {31'h0, idle}, 32'd1);
        check("rst_outs", {27'h0, rq0_resp_valid, rq1_resp_valid, resp_err, rq0_ready, rq1_ready}, 32'd0);
        check("rst_cnts", grant_cnt0 | grant_cnt1 | conflict_cnt, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read after a preload write.
        req(0, 1'b1, 32'h40, 32'hDEADBEEF, gw);
        wait_idle();
        check("wr_ack_count", q0c.size(), 32'd1);
        check("wr_ack_lat", (q0c.size() > 0) ? q0c[0] - gw : -1, 32'd4);
        check("wr_ack_rdata", (q0d.size() > 0) ? q0d[0] : 32'hFFFFFFFF, 32'h0);
        req(0, 1'b0, 32'h40, 32'h0, gr);
        wait_idle();
        check("rd_count", q0c.size(), 32'd2);
        check("rd_lat", (q0c.size() > 1) ? q0c[1] - gr : -1, 32'd4);
        check("rd_data", (q0d.size() > 1) ? q0d[1] : 32'h0, 32'hDEADBEEF);
        check("rd_rq1_quiet", q1c.size(), 32'd0);
        check("rd_grant_cnt0", grant_cnt0, 32'd2);
        check("rd_grant_cnt1", grant_cnt1, 32'd0);
        check("issue_hold", {mem_req_addr[30:0], mem_req_we}, {31'h40, 1'b0});

        // Contention: both valid for 6 cycles from reset.
        do_reset();
        rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'h0;
        rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 32'h4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cont_rdy0", {31'h0, rq0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_rdy1", {31'h0, rq1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        check("cont_conflict", conflict_cnt, 32'd6);
        check("cont_grant0", grant_cnt0, 32'd3);
        check("cont_grant1", grant_cnt1, 32'd3);
        wait_idle();
        check("cont_resps", q0c.size() + q1c.size(), 32'd6);

        // Interleaved routing.
        do_reset();
        s = cyc;
        fork
            req(0, 1'b1, 32'h0, 32'h11111111, g0a);
            req(1, 1'b1, 32'h4, 32'h22222222, g1a);
        join
        wait_idle();
        s = s; // keep start cycle for the write phase
        check("il_wr_g0", g0a - s, 32'd0);
        check("il_wr_g1", g1a - s, 32'd1);
        s = cyc;
        fork
            req(0, 1'b0, 32'h0, 32'h0, g0b);
            req(1, 1'b0, 32'h4, 32'h0, g1b);
        join
        wait_idle();
        check("il_rd_g0", g0b - s, 32'd0);
        check("il_rd_g1", g1b - s, 32'd1);
        check("il_cnt0", q0c.size(), 32'd2);
        check("il_cnt1", q1c.size(), 32'd2);
        check("il_ack0_lat", (q0c.size() > 0) ? q0c[0] - g0a : -1, 32'd4);
        check("il_ack1_lat", (q1c.size() > 0) ? q1c[0] - g1a : -1, 32'd4);
        check("il_ack0_data", (q0d.size() > 0) ? q0d[0] : 32'hFFFFFFFF, 32'h0);
        check("il_ack1_data", (q1d.size() > 0) ? q1d[0] : 32'hFFFFFFFF, 32'h0);
        check("il_rd0_lat", (q0c.size() > 1) ? q0c[1] - g0b : -1, 32'd4);
        check("il_rd1_lat", (q1c.size() > 1) ? q1c[1] - g1b : -1, 32'd4);
        check("il_rd0_data", (q0d.size() > 1) ? q0d[1] : 32'h0, 32'h11111111);
        check("il_rd1_data", (q1d.size() > 1) ? q1d[1] : 32'h0, 32'h22222222);

        // Quiesce: point prio at port 1, then hold both valid with arb_en low.
        do_reset();
        req(0, 1'b0, 32'h0, 32'h0, gq);
        wait_idle();
        arb_en = 1'b0;
        rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'h8;
        rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 32'hC;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("qs_state", {28'h0, rq0_ready, rq1_ready, mem_req_valid, idle}, 32'b0001);
            @(posedge clk);
            #1;
        end
        check("qs_conflict", conflict_cnt, 32'd0);
        arb_en = 1'b1;
        @(negedge clk);
        check("qs_resume", {30'h0, rq0_ready, rq1_ready}, 32'b01);
        @(posedge clk);
        #1;
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        check("qs_grants", {grant_cnt0[15:0], grant_cnt1[15:0]}, {16'd1, 16'd1});
        check("qs_conflict2", conflict_cnt, 32'd1);
        wait_idle();

        // Reset in the middle of a read.
        do_reset();
        req(0, 1'b0, 32'h40, 32'h0, gr);
        check("mf_issue_addr", mem_req_addr, 32'h40);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mf_addr", mem_req_addr, 32'h0);
        check("mf_outs", {28'h0, mem_req_valid, rq0_resp_valid, rq1_resp_valid, resp_err}, 32'd0);
        check("mf_idle", {31'h0, idle}, 32'd1);
        check("mf_cnt0", grant_cnt0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mf_no_resp", q0c.size() + q1c.size(), 32'd0);
        check("mf_no_err", {31'h0, resp_err}, 32'd0);

        // Response with an empty tag pipeline.
        inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        check("pe_err_set", {31'h0, resp_err}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("pe_err_sticky", {31'h0, resp_err}, 32'd1);
        check("pe_no_resp", q0c.size() + q1c.size(), 32'd0);
        check("rdata_zero_when_low", bad_rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
